// File: rtl/hs4_pkg.sv
// Shared types and default parameters for the clocked 4-phase source stage.
package hs4_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ_HI = 2'd1,
    REQ_LO = 2'd2,
    ERR    = 2'd3
  } hs4_state_t;

  localparam int DEF_DATA_W      = 8;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_TIMEOUT     = 255;
  localparam int DEF_TMR_W       = 8;
  localparam int DEF_CNT_W       = 16;

endpackage

// File: rtl/hs_sync.sv
// N-flop 1-bit synchroniser for async-to-clk crossings; resets to 0.
module hs_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk) begin
    if (!rst) ff <= '0;
    else      ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/hs4_src_stage.sv
// Clocked valid/ready feeder driving a self-timed 4-phase stage head (Rin/Ain),
// with ack synchronisation, per-phase timeout and completed-transfer counter.
//
// state  | meaning
// IDLE   | no word in flight, accepts when ack_s low
// REQ_HI | req_out high, waiting for ack rise
// REQ_LO | req_out low, waiting for ack fall
// ERR    | phase timed out; leave on err_clr with ack_s low
module hs4_src_stage
  import hs4_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int TIMEOUT     = DEF_TIMEOUT,
  parameter int TMR_W       = DEF_TMR_W,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              req_out,
  output logic [DATA_W-1:0] data_out,
  input  logic              ack_in,
  input  logic              err_clr,
  output logic              busy,
  output logic              timeout_err,
  output logic [CNT_W-1:0]  done_cnt
);

  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT - 1);

  hs4_state_t       state, state_nxt;
  logic             ack_s;
  logic [TMR_W-1:0] tmr;
  logic             tmr_tc;
  logic             accept;
  logic             done_inc;

  hs_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk (clk),
    .rst (rst),
    .d   (ack_in),
    .q   (ack_s)
  );

  // Down-counter loaded on phase entry; terminal count marks TIMEOUT cycles in the phase.
  assign tmr_tc = (tmr == '0);

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid && in_ready) state_nxt = REQ_HI;
      REQ_HI:  if (ack_s)                state_nxt = REQ_LO;
               else if (tmr_tc)          state_nxt = ERR;
      REQ_LO:  if (!ack_s)               state_nxt = IDLE;
               else if (tmr_tc)          state_nxt = ERR;
      ERR:     if (err_clr && !ack_s)    state_nxt = IDLE;
      default:                           state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = rst && (state == IDLE) && !ack_s;
    busy     = (state != IDLE);
    accept   = (state == IDLE) && in_valid && in_ready;
    done_inc = (state == REQ_LO) && !ack_s;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      req_out     <= 1'b0;
      data_out    <= '0;
      tmr         <= '0;
      done_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (accept) data_out <= in_data;
      req_out     <= (state_nxt == REQ_HI);
      timeout_err <= (state_nxt == ERR);
      if (state_nxt != state)
        tmr <= TMR_LOAD;
      else if ((state == REQ_HI || state == REQ_LO) && !tmr_tc)
        tmr <= tmr - 1'b1;
      if (done_inc) done_cnt <= done_cnt + 1'b1;
    end
  end

endmodule
